// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, ALU strobe bit
// positions, FSM states and opcode classification helpers.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_LSH = 4'd3;
  localparam logic [3:0] OP_RSH = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_INV = 4'd8;
  localparam logic [3:0] OP_LDI = 4'd9;

  localparam int ALU_OP_W = 9;
  localparam int IDX_ADD  = 0;
  localparam int IDX_SUB  = 1;
  localparam int IDX_LSR  = 2;
  localparam int IDX_LSH  = 3;
  localparam int IDX_RSH  = 4;
  localparam int IDX_AND  = 5;
  localparam int IDX_OR   = 6;
  localparam int IDX_XOR  = 7;
  localparam int IDX_INV  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // Execution strobe for an opcode; zero for NOP, LDI and illegal codes.
  function automatic logic [ALU_OP_W-1:0] op_strobe(input logic [3:0] op);
    logic [ALU_OP_W-1:0] s;
    s = '0;
    case (op)
      OP_ADD:  s[IDX_ADD] = 1'b1;
      OP_SUB:  s[IDX_SUB] = 1'b1;
      OP_LSH:  s[IDX_LSH] = 1'b1;
      OP_RSH:  s[IDX_RSH] = 1'b1;
      OP_AND:  s[IDX_AND] = 1'b1;
      OP_OR:   s[IDX_OR]  = 1'b1;
      OP_XOR:  s[IDX_XOR] = 1'b1;
      OP_INV:  s[IDX_INV] = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_INV);
  endfunction

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_LSH) || (op == OP_RSH);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small flop-based register file: one write port, two read ports whose values
// the sequencer latches on accept, a debug read port and a synchronous clear.
module alu_regfile #(
  parameter int NREGS = 4
) (
  input  logic       clk,
  input  logic       i_clr,
  input  logic       i_we,
  input  logic [1:0] i_waddr,
  input  logic [3:0] i_wdata,
  input  logic [1:0] i_raddr1,
  input  logic [1:0] i_raddr2,
  input  logic [1:0] i_dbg_addr,
  output logic [3:0] o_rdata1,
  output logic [3:0] o_rdata2,
  output logic [3:0] o_dbg_data
);

  logic [3:0] r_regs [NREGS];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 4'd0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1   = r_regs[i_raddr1];
  assign o_rdata2   = r_regs[i_raddr2];
  assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Issue controller for the 4-bit ALU: accepts one instruction at a time,
// sequences the LSR preload / execute strobes and writes the result back.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int NREGS       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [3:0]          instr_op,
  input  logic [1:0]          instr_rd,
  input  logic [1:0]          instr_rs1,
  input  logic [1:0]          instr_rs2,
  input  logic [3:0]          instr_imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [3:0]          alu_in1,
  output logic [3:0]          alu_in2,
  input  logic [3:0]          alu_out,
  input  logic                alu_overflow,
  output logic                done,
  output logic                err,
  output logic                flag_v,
  input  logic [1:0]          dbg_addr,
  output logic [3:0]          dbg_data
);

  localparam logic [1:0] CNT_INIT = 2'(ALU_LATENCY - 1);

  state_t              r_state;
  logic [1:0]          r_cnt;
  logic [3:0]          r_op;
  logic [3:0]          r_imm;
  logic [1:0]          r_rd;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic [3:0]          r_alu_in1;
  logic [3:0]          r_alu_in2;
  logic                r_done;
  logic                r_err;
  logic                r_flag_v;

  logic                w_wb_alu;
  logic                w_we;
  logic [3:0]          w_wdata;
  logic [3:0]          w_rdata1;
  logic [3:0]          w_rdata2;

  assign w_wb_alu = is_alu_op(r_op);
  assign w_we     = (r_state == S_WB) && (w_wb_alu || (r_op == OP_LDI));
  assign w_wdata  = w_wb_alu ? alu_out : r_imm;

  alu_regfile #(
    .NREGS(NREGS)
  ) u_regfile (
    .clk       (clk),
    .i_clr     (reset),
    .i_we      (w_we),
    .i_waddr   (r_rd),
    .i_wdata   (w_wdata),
    .i_raddr1  (instr_rs1),
    .i_raddr2  (instr_rs2),
    .i_dbg_addr(dbg_addr),
    .o_rdata1  (w_rdata1),
    .o_rdata2  (w_rdata2),
    .o_dbg_data(dbg_data)
  );

  // Operands are captured into the alu_in registers on accept, so later
  // writebacks cannot disturb an instruction already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      r_op      <= OP_NOP;
      r_imm     <= 4'd0;
      r_rd      <= 2'd0;
      r_alu_op  <= '0;
      r_alu_in1 <= 4'd0;
      r_alu_in2 <= 4'd0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_flag_v  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_op      <= instr_op;
            r_rd      <= instr_rd;
            r_imm     <= instr_imm;
            r_alu_in1 <= w_rdata1;
            r_alu_in2 <= w_rdata2;
            if (is_shift_op(instr_op)) begin
              r_state  <= S_LOAD;
              r_alu_op <= ALU_OP_W'(1) << IDX_LSR;
            end else if (is_alu_op(instr_op)) begin
              r_state  <= S_EXEC;
              r_cnt    <= CNT_INIT;
              r_alu_op <= op_strobe(instr_op);
            end else begin
              r_state <= S_WB;
            end
          end
        end
        S_LOAD: begin
          r_state  <= S_EXEC;
          r_cnt    <= CNT_INIT;
          r_alu_op <= op_strobe(r_op);
        end
        S_EXEC: begin
          if (r_cnt == 2'd0) begin
            r_state <= S_WB;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_WB: begin
          r_state  <= S_IDLE;
          r_alu_op <= '0;
          r_done   <= 1'b1;
          r_err    <= (r_op > OP_LDI);
          if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
            r_flag_v <= alu_overflow;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign alu_op      = r_alu_op;
  assign alu_in1     = r_alu_in1;
  assign alu_in2     = r_alu_in2;
  assign done        = r_done;
  assign err         = r_err;
  assign flag_v      = r_flag_v;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a latency-1 behavioural ALU attached.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_op = 4'd0;
  logic [1:0] instr_rd = 2'd0;
  logic [1:0] instr_rs1 = 2'd0;
  logic [1:0] instr_rs2 = 2'd0;
  logic [3:0] instr_imm = 4'd0;
  logic [8:0] alu_op;
  logic [3:0] alu_in1;
  logic [3:0] alu_in2;
  logic [3:0] alu_out = 4'd0;
  logic       alu_overflow = 1'b0;
  logic       done;
  logic       err;
  logic       flag_v;
  logic [1:0] dbg_addr = 2'd0;
  logic [3:0] dbg_data;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(
    .ALU_LATENCY(1),
    .NREGS      (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .instr_imm   (instr_imm),
    .alu_op      (alu_op),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_out     (alu_out),
    .alu_overflow(alu_overflow),
    .done        (done),
    .err         (err),
    .flag_v      (flag_v),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU, one cycle from strobe to result; LSR preloads the shifter.
  logic [3:0] lsr_m = 4'd0;
  logic [3:0] add_s;
  logic [3:0] sub_d;
  logic       add_v;
  logic       sub_v;
  assign add_s = alu_in1 + alu_in2;
  assign sub_d = alu_in1 - alu_in2;
  assign add_v = (alu_in1[3] == alu_in2[3]) && (add_s[3] != alu_in1[3]);
  assign sub_v = (alu_in1[3] != alu_in2[3]) && (sub_d[3] != alu_in1[3]);

  always @(posedge clk) begin
    case (alu_op)
      9'h001: begin alu_out <= add_s; alu_overflow <= add_v; end
      9'h002: begin alu_out <= sub_d; alu_overflow <= sub_v; end
      9'h004: lsr_m <= alu_in1;
      9'h008: begin alu_out <= {lsr_m[2:0], 1'b0}; alu_overflow <= 1'b0; end
      9'h010: begin alu_out <= {1'b0, lsr_m[3:1]}; alu_overflow <= 1'b0; end
      9'h020: begin alu_out <= alu_in1 & alu_in2; alu_overflow <= 1'b0; end
      9'h040: begin alu_out <= alu_in1 | alu_in2; alu_overflow <= 1'b0; end
      9'h080: begin alu_out <= alu_in1 ^ alu_in2; alu_overflow <= 1'b0; end
      9'h100: begin alu_out <= ~alu_in1; alu_overflow <= 1'b0; end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [3:0] imm;
    logic [3:0] exp_val;      // value of regfile[rd] after completion
    logic       exp_v;
    logic       exp_err;
    int         exp_lat;      // negedges from accept edge to the done cycle
    logic [8:0] exp_strobe;
    int         exp_strobe_cyc;
    int         exp_lsr_cyc;
    logic [3:0] exp_in1;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input int idx, input vec_t v);
    int waited = 0;
    int lat;
    int scyc = 0;
    int lcyc = 0;
    int other = 0;
    logic captured = 1'b0;
    logic [3:0] cap_in1 = 4'd0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("v%0d_ready_before", idx), 32'(instr_ready), 32'd1);
    instr_op    = v.op;
    instr_rd    = v.rd;
    instr_rs1   = v.rs1;
    instr_rs2   = v.rs2;
    instr_imm   = v.imm;
    dbg_addr    = v.rd;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      if (alu_op != 9'h000 && !captured) begin
        captured = 1'b1;
        cap_in1  = alu_in1;
      end
      if (alu_op != 9'h000 && alu_op == v.exp_strobe) scyc++;
      else if (alu_op == 9'h004) lcyc++;
      else if (alu_op != 9'h000) other++;
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d_done_latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
    chk($sformatf("v%0d_ready_at_done", idx), 32'(instr_ready), 32'd1);
    chk($sformatf("v%0d_alu_op_idle", idx), 32'(alu_op), 32'd0);
    chk($sformatf("v%0d_reg", idx), 32'(dbg_data), 32'(v.exp_val));
    chk($sformatf("v%0d_flag_v", idx), 32'(flag_v), 32'(v.exp_v));
    chk($sformatf("v%0d_strobe_cycles", idx), 32'(scyc), 32'(v.exp_strobe_cyc));
    chk($sformatf("v%0d_lsr_cycles", idx), 32'(lcyc), 32'(v.exp_lsr_cyc));
    chk($sformatf("v%0d_stray_strobes", idx), 32'(other), 32'd0);
    if (v.exp_strobe != 9'h000)
      chk($sformatf("v%0d_first_in1", idx), 32'(cap_in1), 32'(v.exp_in1));
    $display("instr %0d op=%0d rd=%0d rs1=%0d rs2=%0d -> r%0d=%h flag_v=%0b err=%0b lat=%0d",
             idx, v.op, v.rd, v.rs1, v.rs2, v.rd, dbg_data, flag_v, err, lat);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse_width", idx), 32'({done, err}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int dones;
    int busy;
    vec_t lv;

    //        op    rd    rs1   rs2   imm   val   v     err   lat strobe  sc lc in1
    vecs[0]  = '{4'd9,  2'd0, 2'd0, 2'd0, 4'd7, 4'h7, 1'b0, 1'b0, 2, 9'h000, 0, 0, 4'h0};
    vecs[1]  = '{4'd9,  2'd1, 2'd0, 2'd0, 4'd5, 4'h5, 1'b0, 1'b0, 2, 9'h000, 0, 0, 4'h0};
    vecs[2]  = '{4'd1,  2'd2, 2'd0, 2'd1, 4'd0, 4'hC, 1'b1, 1'b0, 3, 9'h001, 2, 0, 4'h7};
    vecs[3]  = '{4'd5,  2'd2, 2'd0, 2'd1, 4'd0, 4'h5, 1'b1, 1'b0, 3, 9'h020, 2, 0, 4'h7};
    vecs[4]  = '{4'd6,  2'd2, 2'd0, 2'd1, 4'd0, 4'h7, 1'b1, 1'b0, 3, 9'h040, 2, 0, 4'h7};
    vecs[5]  = '{4'd7,  2'd2, 2'd0, 2'd1, 4'd0, 4'h2, 1'b1, 1'b0, 3, 9'h080, 2, 0, 4'h7};
    vecs[6]  = '{4'd8,  2'd2, 2'd0, 2'd1, 4'd0, 4'h8, 1'b1, 1'b0, 3, 9'h100, 2, 0, 4'h7};
    vecs[7]  = '{4'd3,  2'd3, 2'd0, 2'd1, 4'd0, 4'hE, 1'b1, 1'b0, 4, 9'h008, 2, 1, 4'h7};
    vecs[8]  = '{4'd4,  2'd3, 2'd0, 2'd1, 4'd0, 4'h3, 1'b1, 1'b0, 4, 9'h010, 2, 1, 4'h7};
    vecs[9]  = '{4'd12, 2'd0, 2'd0, 2'd1, 4'd3, 4'h7, 1'b1, 1'b1, 2, 9'h000, 0, 0, 4'h0};
    vecs[10] = '{4'd0,  2'd1, 2'd0, 2'd1, 4'd3, 4'h5, 1'b1, 1'b0, 2, 9'h000, 0, 0, 4'h0};
    vecs[11] = '{4'd2,  2'd3, 2'd0, 2'd1, 4'd0, 4'h2, 1'b0, 1'b0, 3, 9'h002, 2, 0, 4'h7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_in", 32'({alu_in1, alu_in2}), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_flag_v", 32'(flag_v), 32'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk($sformatf("rst_reg%0d", i), 32'(dbg_data), 32'd0);
    end

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Hold instr_valid through a whole ADD (r2 = r1 + r1 = 5 + 5).
    @(negedge clk);
    instr_op    = 4'd1;
    instr_rd    = 2'd2;
    instr_rs1   = 2'd1;
    instr_rs2   = 2'd1;
    dbg_addr    = 2'd2;
    instr_valid = 1'b1;
    accepts = 0;
    dones   = 0;
    busy    = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) dones++;
      if (!instr_ready) busy++;
      if (instr_valid && instr_ready) begin
        if (accepts == 0) accepts++;
        else instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("held_accepts", 32'(accepts), 32'd1);
    chk("held_done_pulses", 32'(dones), 32'd1);
    chk("held_busy_cycles", 32'(busy), 32'd2);
    chk("held_r2", 32'(dbg_data), 32'hA);
    chk("held_flag_v", 32'(flag_v), 32'd1);
    $display("instr held-valid ADD r2=r1+r1 -> r2=%h accepts=%0d dones=%0d busy=%0d",
             dbg_data, accepts, dones, busy);

    // Reset while an AND is executing.
    instr_op    = 4'd5;
    instr_rd    = 2'd3;
    instr_rs1   = 2'd0;
    instr_rs2   = 2'd1;
    instr_valid = 1'b1;
    @(negedge clk);
    chk("mid_exec_alu_op", 32'(alu_op), 32'h020);
    instr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rst_ready", 32'(instr_ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_flag_v", 32'(flag_v), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk($sformatf("mid_rst_reg%0d", i), 32'(dbg_data), 32'd0);
    end
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("mid_rst_no_done", 32'(dones), 32'd0);
    $display("instr AND interrupted by reset -> alu_op=%h ready=%0b", alu_op, instr_ready);

    lv = '{4'd9, 2'd1, 2'd0, 2'd0, 4'd9, 4'h9, 1'b0, 1'b0, 2, 9'h000, 0, 0, 4'h0};
    run_vec(12, lv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Issue controller for the 4-bit ArithmeticLogicUnit. It accepts one encoded instruction at a time over a valid/ready handshake and reads operands from a local 4x4-bit register file. It drives the ALU's one-hot operation strobes, including the LSR preload that must precede any LSH/RSH. It writes the ALU result back and reports completion and overflow to the fetch stage.

Parameters:
ALU_LATENCY, 1, cycles from strobe assertion until alu_out/alu_overflow are valid (range 1-4)
NREGS, 4, register file depth (address width fixed at 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer idle and able to accept
instr_op  input  4  encoded opcode (see Behaviour)
instr_rd  input  2  destination register
instr_rs1  input  2  source 1, drives alu_in1
instr_rs2  input  2  source 2, drives alu_in2
instr_imm  input  4  immediate for LDI
alu_op  output  9  one-hot ALU strobes: [0]ADD [1]SUB [2]LSR [3]LSH [4]RSH [5]AND [6]OR [7]XOR [8]INV
alu_in1  output  4  ALU operand 1
alu_in2  output  4  ALU operand 2
alu_out  input  4  ALU result
alu_overflow  input  1  ALU overflow
done  output  1  one-cycle completion pulse
err  output  1  one-cycle illegal-opcode pulse
flag_v  output  1  sticky overflow flag from last ADD/SUB
dbg_addr  input  2  debug read address
dbg_data  output  4  combinational read of regfile[dbg_addr]

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: FSM=IDLE; alu_op=0; alu_in1=alu_in2=0; done=err=0; flag_v=0; all registers=0; instr_ready=1.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 LSH, 4 RSH, 5 AND, 6 OR, 7 XOR, 8 INV, 9 LDI. Codes 10-15 are illegal.
- instr_ready=1 only in IDLE. Accept occurs on a rising edge with instr_valid&instr_ready.
- On accept, latch op, rd, imm and the operand values regfile[rs1] and regfile[rs2]. Later writes therefore never affect an in-flight op, and rd==rs1/rs2 is legal.
- IDLE -> LOAD: op is LSH or RSH.
- IDLE -> EXEC: op is ADD, SUB, AND, OR, XOR or INV.
- IDLE -> WB: op is NOP, LDI or illegal.
- LOAD (1 cycle): alu_op=LSR only, alu_in1=operand1 -> EXEC.
- EXEC (ALU_LATENCY cycles, down-counter): alu_op=the op's single strobe, alu_in1/alu_in2=latched operands -> WB.
- WB (1 cycle):
  - ALU ops keep the same strobe and operands.
  - done=1 for every opcode, including illegal ones.
  - ALU ops: regfile[rd]<=alu_out at the end of WB.
  - LDI: regfile[rd]<=imm.
  - NOP: no write.
  - ADD/SUB: flag_v<=alu_overflow. Other ops leave flag_v unchanged.
  - Illegal: err=1, no write, flag_v unchanged.
  - WB -> IDLE.
- alu_op is 0 in IDLE and is never more than one-hot.
- Occupancy (accept edge to next possible accept):
  - ALU op: ALU_LATENCY+2 cycles.
  - Shift op: ALU_LATENCY+3 cycles.
  - NOP/LDI/illegal: 2 cycles.
- instr_valid while busy is ignored. The offering side must hold the instruction until the handshake completes.
- Reset in any state returns to IDLE on that edge, clears the register file, and forces alu_op=0 with no pending writeback.
- dbg_data reflects a write on the cycle after the write edge.
- Arithmetic: all data is 4 bits. Results are taken from alu_out unmodified; no sign extension or saturation.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_NOP..OP_LDI;
  - one-hot strobe indices IDX_ADD..IDX_INV and ALU_OP_W=9;
  - FSM state encodings S_IDLE, S_LOAD, S_EXEC, S_WB.
- One sub-module: alu_regfile (4x4, one synchronous write port, two latched-read ports plus the combinational debug port, synchronous clear).
- Decode, FSM and latency counter stay in alu_sequencer.

Test Plan:
- LDI r0=7, LDI r1=5, then ADD rd=2 rs1=0 rs2=1, bench ALU latency 1 -> alu_op=9'h001 for 2 cycles; done 3 cycles after accept; dbg r2=4'hC; flag_v=alu_overflow.
- SUB r3=r0-r1 with r0=7, r1=5 -> r3=4'h2; next instruction accepted on the cycle after done.
- LSH rd=3 rs1=0 with r0=7 -> exactly one cycle alu_op=9'h004 and alu_in1=7, then alu_op=9'h008; r3=4'hE. RSH of 7 -> r3=4'h3.
- instr_valid held high across a full ADD -> instr_ready low until IDLE; exactly one accept and one done pulse; no duplicate write.
- instr_op=12 -> err and done pulse together after 2 cycles; all registers and flag_v unchanged; alu_op stays 0.
- reset asserted mid-EXEC of AND -> alu_op=0 and all registers 0 after that edge; no done; instr_ready=1; next LDI completes normally.
